mul_share_arbiter: RTL and testbench

Shares one multiplier instance (`Mul`, DATA_WIDTH x DATA_WIDTH -> OUT_WIDTH, fixed latency) between NUM_REQ requesters in the SC-CGRA datapath. Requesters use valid/ready handshakes, and grants are round-robin. The block holds the operands stable on the multiplier for its full latency, then returns the product tagged with the requester ID on a valid/ready response channel.

---
 rtl/mul_share_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one fixed-latency multiplier between NUM_REQ requesters. In IDLE a
// winner is picked from the requesters with req_valid set, and its operands are
// captured into the operand registers. Those registers drive mul_a/mul_b and
// stay stable for MUL_LATENCY cycles (EXEC). The product is then registered and
// offered on a valid/ready response channel, tagged with the requester index
// (RESP). No new grant is issued until the response has been accepted.
//
// Arbitration: round-robin by default. The search starts just after the last
// granted requester, so the requester served last has lowest priority. Define
// the macro MUL_SHARE_FIXED_PRIO_EN to use fixed priority instead, where the
// lowest-index valid requester always wins.
//
// Parameters:
//   DATA_WIDTH   operand width
//   OUT_WIDTH    product width (>= 2*DATA_WIDTH)
//   NUM_REQ      number of requesters (2..16)
//   MUL_LATENCY  cycles from stable operands to valid mul_result (>= 1)
//   ID_W         requester index width (derived)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   per-requester request
//   req_ready   per-requester grant, one-hot or zero, combinational in IDLE
//   req_a       packed operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_b       packed operand B, same packing
//   mul_a       operand to the shared multiplier (io_inputs_1)
//   mul_b       operand to the shared multiplier (io_inputs_0)
//   mul_result  product from the shared multiplier (io_outs_0)
//   resp_valid  response available
//   resp_ready  consumer accepts the response
//   resp_id     requester index of the response
//   resp_data   registered product
//   busy        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_WIDTH   = 16,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic [OUT_WIDTH-1:0]          mul_result,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [OUT_WIDTH-1:0]          resp_data,
  output logic                          busy
);

  // The counter only has to hold MUL_LATENCY-1.
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [ID_W-1:0]         id_reg;
  logic [CNT_W-1:0]        cnt;

  logic                    win_found;
  logic [ID_W-1:0]         win_id;
  logic                    grant;
  logic [DATA_WIDTH-1:0]   win_a;
  logic [DATA_WIDTH-1:0]   win_b;

`ifdef MUL_SHARE_FIXED_PRIO_EN
  // Fixed priority. The scan runs from the top index down, so the lowest
  // valid index is the last one assigned and wins.
  always_comb begin
    // NOTE: every variable written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] last_grant;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input int             offs);
    return ID_W'((int'(base) + offs) % NUM_REQ);
  endfunction

  // Round-robin. Offsets are scanned from farthest (last_grant itself) to
  // nearest (last_grant+1), so the nearest valid requester is the last
  // one assigned and wins.
  always_comb begin
    // NOTE: every variable written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[rr_idx(last_grant, k)]) begin
        win_found = 1'b1;
        win_id    = rr_idx(last_grant, k);
      end
    end
  end
`endif

  // A grant is offered only in IDLE, so a handshake is exactly `grant`.
  assign grant = (state == IDLE) && win_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;
  end

  assign win_a = req_a[int'(win_id) * DATA_WIDTH +: DATA_WIDTH];
  assign win_b = req_b[int'(win_id) * DATA_WIDTH +: DATA_WIDTH];

  // The multiplier sees only the operand registers. They are written only on
  // a handshake, so the operands do not toggle outside EXEC.
  assign mul_a = a_reg;
  assign mul_b = b_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: all sequential state here uses non-blocking assignments, so
      // every register sees pre-edge values regardless of statement order.
      state      <= IDLE;
`ifndef MUL_SHARE_FIXED_PRIO_EN
      last_grant <= ID_W'(NUM_REQ - 1);
`endif
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            a_reg      <= win_a;
            b_reg      <= win_b;
            id_reg     <= win_id;
`ifndef MUL_SHARE_FIXED_PRIO_EN
            last_grant <= win_id;
`endif
            cnt        <= CNT_LOAD;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            resp_data  <= mul_result;
            resp_id    <= id_reg;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
//
// Directed test bench for mul_share_arbiter. It uses two instances:
//   u_dut   MUL_LATENCY=1. The multiplier model is combinational, so the
//           product is ready at the single EXEC capture edge.
//   u_dut3  MUL_LATENCY=3. The multiplier model has two register stages, so
//           the product is ready at the third EXEC edge.
// Arbitration expectations follow MUL_SHARE_FIXED_PRIO_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mul_share_arbiter;

`ifdef MUL_SHARE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;

  // Latency-1 instance
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_result;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_id;
  logic [15:0] resp_data;
  logic        busy;

  // Latency-3 instance
  logic [3:0]  req_valid3, req_ready3;
  logic [31:0] req_a3, req_b3;
  logic [7:0]  mul_a3, mul_b3;
  logic [15:0] mul_result3;
  logic        resp_valid3, resp_ready3;
  logic [1:0]  resp_id3;
  logic [15:0] resp_data3;
  logic        busy3;
  logic [15:0] p1, p2;

  mul_share_arbiter #(.DATA_WIDTH(8), .OUT_WIDTH(16), .NUM_REQ(4), .MUL_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  mul_share_arbiter #(.DATA_WIDTH(8), .OUT_WIDTH(16), .NUM_REQ(4), .MUL_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .mul_a(mul_a3), .mul_b(mul_b3),
    .mul_result(mul_result3), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_id(resp_id3), .resp_data(resp_data3), .busy(busy3)
  );

  // Multiplier models
  assign mul_result = {8'd0, mul_a} * {8'd0, mul_b};
  always @(posedge clk) begin
    p1 <= {8'd0, mul_a3} * {8'd0, mul_b3};
    p2 <= p1;
  end
  assign mul_result3 = p2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits up to 20 cycles for resp_valid on u_dut; got=0 on timeout.
  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; resp_ready3 = 1'b0;
    #2;
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b expected 0", resp_valid); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_run++; if (resp_data !== 16'd0) begin n_fail++; $display("FAIL reset_resp_data: got %0d expected 0", resp_data); end
    n_run++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    n_run++; if ({mul_a, mul_b} !== 16'd0) begin n_fail++; $display("FAIL reset_operands: got %0d/%0d expected 0/0", mul_a, mul_b); end
    n_run++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_a[7:0] = 8'd11; req_b[7:0] = 8'd12; resp_ready = 1'b1;
    #1;
    n_run++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_run++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_exec: got %b expected 0000", req_ready); end
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_exec: got %0b expected 1", busy); end
    n_run++; if ({mul_a, mul_b} !== {8'd11, 8'd12}) begin n_fail++; $display("FAIL single_operands: got %0d/%0d expected 11/12", mul_a, mul_b); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_resp: got %0b expected 0", resp_valid); end
    tick();
    n_run++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL single_resp_valid: got %0b expected 1", resp_valid); end
    n_run++; if (resp_data !== 16'd132) begin n_fail++; $display("FAIL single_data: got %0d expected 132", resp_data); end
    n_run++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", resp_id); end
    tick();
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_resp_drop: got %0b expected 0", resp_valid); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %0b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    bit          got;
    int          prev_cyc;
    logic [1:0]  eid;
    logic [15:0] edata;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'd3;
    end
    req_valid = 4'b1111; resp_ready = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_resp(got);
      eid   = FIXED ? 2'd0 : 2'(k % 4);
      edata = 16'((int'(eid) + 1) * 3);
      n_run++; if (!got) begin n_fail++; $display("FAIL rr_timeout_%0d: got no response expected one", k); end
      n_run++; if (resp_id !== eid) begin n_fail++; $display("FAIL rr_id_%0d: got %0d expected %0d", k, resp_id, eid); end
      n_run++; if (resp_data !== edata) begin n_fail++; $display("FAIL rr_data_%0d: got %0d expected %0d", k, resp_data, edata); end
      if (k > 0) begin
        n_run++; if (cyc - prev_cyc != 3) begin n_fail++; $display("FAIL rr_spacing_%0d: got %0d expected 3", k, cyc - prev_cyc); end
      end
      prev_cyc = cyc;
      if (k == 4) req_valid = 4'b0000;
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit got;
    req_valid = 4'b0100; req_a[23:16] = 8'd255; req_b[23:16] = 8'd255;
    req_a[15:8] = 8'd5; req_b[15:8] = 8'd6; resp_ready = 1'b0;
    #1;
    n_run++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant2: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b0010;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_run++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %0b expected 1", k, resp_valid); end
      n_run++; if (resp_data !== 16'd65025) begin n_fail++; $display("FAIL bp_data_%0d: got %0d expected 65025", k, resp_data); end
      n_run++; if (resp_id !== 2'd2) begin n_fail++; $display("FAIL bp_id_%0d: got %0d expected 2", k, resp_id); end
      n_run++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant_%0d: got %b expected 0000", k, req_ready); end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    n_run++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant_release: got %b expected 0000", req_ready); end
    tick();
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_resp_drop: got %0b expected 0", resp_valid); end
    n_run++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_resp(got);
    n_run++; if (!got || resp_id !== 2'd1 || resp_data !== 16'd30) begin n_fail++; $display("FAIL bp_req1_resp: got id %0d data %0d expected id 1 data 30", resp_id, resp_data); end
    tick();
  endtask

  task automatic test_latency3();
    req_valid3 = 4'b0001; req_a3[7:0] = 8'd200; req_b3[7:0] = 8'd7; resp_ready3 = 1'b1;
    #1;
    n_run++; if (req_ready3 !== 4'b0001) begin n_fail++; $display("FAIL l3_grant: got %b expected 0001", req_ready3); end
    tick();
    req_valid3 = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      n_run++; if ({mul_a3, mul_b3} !== {8'd200, 8'd7}) begin n_fail++; $display("FAIL l3_operands_%0d: got %0d/%0d expected 200/7", k, mul_a3, mul_b3); end
      n_run++; if (resp_valid3 !== 1'b0) begin n_fail++; $display("FAIL l3_early_%0d: got %0b expected 0", k, resp_valid3); end
      tick();
    end
    n_run++; if (resp_valid3 !== 1'b1) begin n_fail++; $display("FAIL l3_valid: got %0b expected 1", resp_valid3); end
    n_run++; if (resp_data3 !== 16'd1400) begin n_fail++; $display("FAIL l3_data: got %0d expected 1400", resp_data3); end
    n_run++; if (resp_id3 !== 2'd0) begin n_fail++; $display("FAIL l3_id: got %0d expected 0", resp_id3); end
    tick();
    n_run++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL l3_busy_end: got %0b expected 0", busy3); end
    n_run++; if (mul_a3 !== 8'd200) begin n_fail++; $display("FAIL l3_operand_hold: got %0d expected 200", mul_a3); end
  endtask

  task automatic test_reset_mid();
    bit got;
    req_valid = 4'b0001; req_a[7:0] = 8'd9; req_b[7:0] = 8'd9; resp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_exec: got %0b expected 1", busy); end
    #1 rst = 1'b1;
    #1;
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_resp_valid: got %0b expected 0", resp_valid); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %0b expected 0", busy); end
    n_run++; if (resp_data !== 16'd0) begin n_fail++; $display("FAIL rm_resp_data: got %0d expected 0", resp_data); end
    n_run++; if (mul_a !== 8'd0) begin n_fail++; $display("FAIL rm_mul_a: got %0d expected 0", mul_a); end
    rst = 1'b0;
    req_valid = 4'b0011;
    req_a[7:0] = 8'd4; req_b[7:0] = 8'd5; req_a[15:8] = 8'd6; req_b[15:8] = 8'd7;
    #1;
    n_run++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_grant0: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_resp(got);
    n_run++; if (!got || resp_id !== 2'd0 || resp_data !== 16'd20) begin n_fail++; $display("FAIL rm_first_resp: got id %0d data %0d expected id 0 data 20", resp_id, resp_data); end
    tick();
  endtask

  task automatic test_priority();
    bit          got;
    logic [1:0]  eid;
    logic [15:0] edata;
    do_reset();
    req_a[7:0] = 8'd1;   req_b[7:0] = 8'd2;
    req_a[31:24] = 8'd3; req_b[31:24] = 8'd4;
    req_valid = 4'b1001; resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_resp(got);
      eid   = (FIXED || (k % 2 == 0)) ? 2'd0 : 2'd3;
      edata = (eid == 2'd0) ? 16'd2 : 16'd12;
      n_run++; if (!got || resp_id !== eid || resp_data !== edata) begin n_fail++; $display("FAIL prio_%0d: got id %0d data %0d expected id %0d data %0d", k, resp_id, resp_data, eid, edata); end
      if (k == 3) req_valid = 4'b1000;
      tick();
    end
    wait_resp(got);
    n_run++; if (!got || resp_id !== 2'd3 || resp_data !== 16'd12) begin n_fail++; $display("FAIL prio_after_drop: got id %0d data %0d expected id 3 data 12", resp_id, resp_data); end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency3();
    test_reset_mid();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
